mem_wr: RTL and testbench

MEM_WR -- requirements
Module: mem_wr

---
 rtl/mem_wr.sv | 127 ++++++++++++
 tb/tb_mem_wr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr.sv
// FIFO-to-BRAM frame writer: drains one frame of pixels from a source FIFO into
// BRAM in address order, then raises a registered frame-ready level for the reader.
module mem_wr #(
    parameter  int BRAM_DEPTH = 16384,
    parameter  int DATA_WIDTH = 12,
    parameter  int REQ_HOLD   = 4,
    localparam int AW         = $clog2(BRAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_empty,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_wr,
    output logic [AW-1:0]         o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_req,
    output logic                  o_frame_done,
    output logic                  o_drop
);

    localparam int HW = $clog2(REQ_HOLD + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [AW:0]   RD_LIMIT  = (AW+1)'(BRAM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REQ_HOLD - 1);

    logic [1:0]    state;
    logic [AW:0]   rd_cnt;
    logic [AW-1:0] wr_ptr;
    logic          valid;
    logic [HW-1:0] hold_cnt;
    logic          write_now;
    logic          last_wr;

    // Reads are only issued while a frame is open and not every word has been requested yet.
    assign o_rd      = (state == S_ACTIVE) && !i_empty && (rd_cnt < RD_LIMIT);
    assign write_now = valid && (state == S_ACTIVE);
    assign last_wr   = write_now && (wr_ptr == LAST_ADDR);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    hold_cnt <= '0;
                    if (i_start) begin
                        state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (last_wr) begin
                        state    <= S_DONE;
                        hold_cnt <= '0;
                    end
                end
                S_DONE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // o_req is high for exactly the cycles spent in DONE, hence the early drop on the last hold cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_req  <= 1'b0;
            o_drop <= 1'b0;
        end else begin
            o_req  <= last_wr || ((state == S_DONE) && (hold_cnt != HOLD_LAST));
            o_drop <= i_start && (state != S_IDLE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_cnt <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= o_rd;
            if (state != S_ACTIVE) begin
                rd_cnt <= '0;
            end else if (o_rd) begin
                rd_cnt <= rd_cnt + (AW+1)'(1);
            end
        end
    end

    // Write port: address and data hold their last value between writes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wr         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_frame_done <= 1'b0;
            wr_ptr       <= '0;
        end else begin
            o_wr         <= write_now;
            o_frame_done <= last_wr;
            if (write_now) begin
                o_waddr <= wr_ptr;
                o_wdata <= i_rdata;
            end
            if (state == S_IDLE || last_wr) begin
                wr_ptr <= '0;
            end else if (write_now) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wr.sv
// Directed bench for mem_wr: a cycle table for one full frame plus hand-written
// sequences for stalls, back-to-back frames and mid-frame reset.
module tb_mem_wr;

    localparam int DEPTH = 16;
    localparam int DW    = 12;
    localparam int HOLD  = 4;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_start;
    logic          i_empty;
    logic          o_rd;
    logic [DW-1:0] i_rdata;
    logic          o_wr;
    logic [3:0]    o_waddr;
    logic [DW-1:0] o_wdata;
    logic          o_req;
    logic          o_frame_done;
    logic          o_drop;

    int applied     = 0;
    int miscompares = 0;

    logic [DW-1:0] fifo[$];
    logic          stall;
    logic          rd_prev;

    typedef struct {
        logic          start;
        logic          rd;
        logic          wr;
        logic [3:0]    waddr;
        logic [DW-1:0] wdata;
        logic          req;
        logic          done;
        logic          drop;
    } vec_t;

    vec_t vecs[25];

    mem_wr #(.BRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .REQ_HOLD(HOLD)) dut (
        .i_clk(i_clk),
        .i_rstn(i_rstn),
        .i_start(i_start),
        .i_empty(i_empty),
        .o_rd(o_rd),
        .i_rdata(i_rdata),
        .o_wr(o_wr),
        .o_waddr(o_waddr),
        .o_wdata(o_wdata),
        .o_req(o_req),
        .o_frame_done(o_frame_done),
        .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stall_in);
        i_start = start;
        stall   = stall_in;
        i_empty = stall || (fifo.size() == 0);
        #1;
    endtask

    // The FIFO model presents the popped word for the whole cycle after a read.
    task automatic nextCycle();
        rd_prev = o_rd;
        @(posedge i_clk);
        #1;
        if (rd_prev && fifo.size() > 0) begin
            i_rdata = fifo.pop_front();
        end
    endtask

    task automatic loadFifo(input logic [DW-1:0] base, input int n);
        fifo.delete();
        for (int k = 0; k < n; k++) begin
            fifo.push_back(base + DW'(k));
        end
    endtask

    task automatic runFrame(input logic toggle, input logic [DW-1:0] base);
        int   nwr;
        int   nreq;
        int   ndone;
        logic rd_d1;
        logic rd_d2;
        logic seen_req;
        logic finished;
        nwr = 0; nreq = 0; ndone = 0;
        rd_d1 = 1'b0; rd_d2 = 1'b0; seen_req = 1'b0; finished = 1'b0;
        loadFifo(base, DEPTH);
        for (int t = 0; t < 200 && !finished; t++) begin
            applyStimulus(t == 0, toggle && t[0]);
            checkOutput("frame o_wr follows o_rd by two", o_wr, rd_d2);
            if (o_wr) begin
                checkOutput("frame waddr", o_waddr, nwr);
                checkOutput("frame wdata", o_wdata, 32'(base) + nwr);
                nwr++;
            end
            if (o_frame_done) begin
                ndone++;
                checkOutput("frame_done addr", o_waddr, DEPTH - 1);
                checkOutput("frame_done with wr", o_wr, 1);
            end
            if (o_req) begin
                nreq++;
                seen_req = 1'b1;
            end else if (seen_req) begin
                finished = 1'b1;
            end
            rd_d2 = rd_d1;
            rd_d1 = o_rd;
            if (!finished) nextCycle();
        end
        if (!finished) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL frame timeout: got no o_req fall, expected return to IDLE");
        end
        checkOutput("frame write count", nwr, DEPTH);
        checkOutput("frame o_req cycles", nreq, HOLD);
        checkOutput("frame done pulses", ndone, 1);
        checkOutput("frame o_rd in IDLE", o_rd, 0);
    endtask

    initial begin
        // start rd wr waddr wdata req done drop
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'h0, 12'h100, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'h1, 12'h101, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'h2, 12'h102, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'h3, 12'h103, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h4, 12'h104, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'h5, 12'h105, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h6, 12'h106, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'h7, 12'h107, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 4'h8, 12'h108, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'h9, 12'h109, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 4'hA, 12'h10A, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 4'hB, 12'h10B, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 4'hC, 12'h10C, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 4'hD, 12'h10D, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 4'hE, 12'h10E, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 4'hF, 12'h10F, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 4'hF, 12'h10F, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 4'hF, 12'h10F, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 4'hF, 12'h10F, 1'b1, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 4'hF, 12'h10F, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 4'hF, 12'h10F, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 4'hF, 12'h10F, 1'b0, 1'b0, 1'b0};

        i_rstn  = 1'b0;
        i_start = 1'b0;
        stall   = 1'b0;
        i_empty = 1'b1;
        i_rdata = '0;
        rd_prev = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset o_rd", o_rd, 0);
        checkOutput("reset o_wr", o_wr, 0);
        checkOutput("reset o_waddr", o_waddr, 0);
        checkOutput("reset o_wdata", o_wdata, 0);
        checkOutput("reset o_req", o_req, 0);
        checkOutput("reset o_frame_done", o_frame_done, 0);
        checkOutput("reset o_drop", o_drop, 0);
        i_rstn = 1'b1;

        // Twenty words queued: exactly sixteen must be consumed, with starts dropped mid-frame and in DONE.
        loadFifo(12'h100, 20);
        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].start, 1'b0);
            checkOutput($sformatf("vec%0d o_rd", i), o_rd, vecs[i].rd);
            checkOutput($sformatf("vec%0d o_wr", i), o_wr, vecs[i].wr);
            checkOutput($sformatf("vec%0d o_waddr", i), o_waddr, vecs[i].waddr);
            checkOutput($sformatf("vec%0d o_wdata", i), o_wdata, vecs[i].wdata);
            checkOutput($sformatf("vec%0d o_req", i), o_req, vecs[i].req);
            checkOutput($sformatf("vec%0d o_frame_done", i), o_frame_done, vecs[i].done);
            checkOutput($sformatf("vec%0d o_drop", i), o_drop, vecs[i].drop);
            nextCycle();
        end
        checkOutput("fifo words left", fifo.size(), 4);

        runFrame(1'b1, 12'h200);
        runFrame(1'b0, 12'h300);
        runFrame(1'b0, 12'h380);

        // Mid-frame reset right after address 9 is written.
        begin
            logic hit;
            hit = 1'b0;
            loadFifo(12'h500, DEPTH);
            for (int t = 0; t < 60 && !hit; t++) begin
                applyStimulus(t == 0, 1'b0);
                if (o_wr && o_waddr == 4'd9) hit = 1'b1;
                else nextCycle();
            end
            if (!hit) begin
                applied++;
                miscompares++;
                $display("[TB] FAIL reset seq timeout: got no write to 9, expected one");
            end
            #2;
            i_rstn = 1'b0;
            #1;
            checkOutput("async rst o_rd", o_rd, 0);
            checkOutput("async rst o_wr", o_wr, 0);
            checkOutput("async rst o_waddr", o_waddr, 0);
            checkOutput("async rst o_wdata", o_wdata, 0);
            checkOutput("async rst o_req", o_req, 0);
            checkOutput("async rst o_frame_done", o_frame_done, 0);
            checkOutput("async rst o_drop", o_drop, 0);
            @(posedge i_clk);
            #1;
            i_rstn = 1'b1;
            loadFifo(12'h600, DEPTH);
            for (int t = 0; t < 4; t++) begin
                applyStimulus(1'b0, 1'b0);
                checkOutput("post-reset idle o_wr", o_wr, 0);
                checkOutput("post-reset idle o_rd", o_rd, 0);
                nextCycle();
            end
        end
        runFrame(1'b0, 12'h700);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
